// File: rtl/instr_encoder_if.sv
// Load-port bundle for the RV32IM instruction encoder.
// master = program loader, slave = encoder.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
);
  logic                   START;
  logic [ADDR_WIDTH-1:0]  BASE_ADDR;
  logic                   IN_VALID;
  logic                   IN_READY;
  logic [2:0]             FORMAT;
  logic [6:0]             OPCODE;
  logic [2:0]             FUNCT3;
  logic [6:0]             FUNCT7;
  logic [4:0]             RD;
  logic [4:0]             RS1;
  logic [4:0]             RS2;
  logic [31:0]            IMM;
  logic                   LAST;
  logic                   MEM_WRITE;
  logic [ADDR_WIDTH-1:0]  MEM_ADDR;
  logic [31:0]            MEM_WRITEDATA;
  logic                   MEM_BUSYWAIT;
  logic [COUNT_WIDTH-1:0] COUNT;
  logic                   ERROR;
  logic                   DONE;

  modport master (
    output START, BASE_ADDR, IN_VALID,
    output FORMAT, OPCODE, FUNCT3, FUNCT7,
    output RD, RS1, RS2, IMM, LAST,
    output MEM_BUSYWAIT,
    input  IN_READY, MEM_WRITE, MEM_ADDR,
    input  MEM_WRITEDATA, COUNT, ERROR, DONE
  );

  modport slave (
    input  START, BASE_ADDR, IN_VALID,
    input  FORMAT, OPCODE, FUNCT3, FUNCT7,
    input  RD, RS1, RS2, IMM, LAST,
    input  MEM_BUSYWAIT,
    output IN_READY, MEM_WRITE, MEM_ADDR,
    output MEM_WRITEDATA, COUNT, ERROR, DONE
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs RV32IM field bundles into instruction words and
// streams them into instruction memory at consecutive addresses.
module instr_encoder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  instr_encoder_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ENCODE,
    WRITE,
    FINISH
  } state_t;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        last;
  } fields_t;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  state_t                 state_q, state_d;
  fields_t                fld_q, fld_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   err_q, err_d;

  logic [31:0] word;
  logic        legal;
  logic        is_shift;
  logic        fits12;
  logic        fits_b;
  logic        fits_j;

  // Word assembly and legality checks on the captured bundle
  always_comb begin
    word     = '0;
    is_shift = (fld_q.op == 7'b0010011) &&
               ((fld_q.f3 == 3'b001) ||
                (fld_q.f3 == 3'b101));
    // An immediate fits N signed bits when all bits
    // above the sign bit copy it.
    fits12   = (fld_q.imm[31:11] == '0) ||
               (fld_q.imm[31:11] == '1);
    fits_b   = ((fld_q.imm[31:12] == '0) ||
                (fld_q.imm[31:12] == '1)) &&
               !fld_q.imm[0];
    fits_j   = ((fld_q.imm[31:20] == '0) ||
                (fld_q.imm[31:20] == '1)) &&
               !fld_q.imm[0];
    legal    = (fld_q.op[1:0] == 2'b11);
    unique case (fld_q.fmt)
      FMT_R: begin
        word = {fld_q.f7, fld_q.rs2, fld_q.rs1,
                fld_q.f3, fld_q.rd, fld_q.op};
      end
      FMT_I: begin
        if (is_shift) begin
          word  = {fld_q.f7, fld_q.imm[4:0],
                   fld_q.rs1, fld_q.f3,
                   fld_q.rd, fld_q.op};
          legal = legal &&
                  (fld_q.imm[31:5] == '0);
        end else begin
          word  = {fld_q.imm[11:0], fld_q.rs1,
                   fld_q.f3, fld_q.rd, fld_q.op};
          legal = legal && fits12;
        end
      end
      FMT_S: begin
        word  = {fld_q.imm[11:5], fld_q.rs2,
                 fld_q.rs1, fld_q.f3,
                 fld_q.imm[4:0], fld_q.op};
        legal = legal && fits12;
      end
      FMT_B: begin
        word  = {fld_q.imm[12], fld_q.imm[10:5],
                 fld_q.rs2, fld_q.rs1, fld_q.f3,
                 fld_q.imm[4:1], fld_q.imm[11],
                 fld_q.op};
        legal = legal && fits_b;
      end
      FMT_U: begin
        word  = {fld_q.imm[31:12], fld_q.rd,
                 fld_q.op};
        legal = legal &&
                (fld_q.imm[11:0] == '0);
      end
      FMT_J: begin
        word  = {fld_q.imm[20], fld_q.imm[10:1],
                 fld_q.imm[11], fld_q.imm[19:12],
                 fld_q.rd, fld_q.op};
        legal = legal && fits_j;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Session sequencing: next state and register updates
  always_comb begin
    state_d = state_q;
    fld_d   = fld_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          addr_d  = bus.BASE_ADDR;
          count_d = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (bus.IN_VALID) begin
          fld_d.fmt  = bus.FORMAT;
          fld_d.op   = bus.OPCODE;
          fld_d.f3   = bus.FUNCT3;
          fld_d.f7   = bus.FUNCT7;
          fld_d.rd   = bus.RD;
          fld_d.rs1  = bus.RS1;
          fld_d.rs2  = bus.RS2;
          fld_d.imm  = bus.IMM;
          fld_d.last = bus.LAST;
          state_d    = ENCODE;
        end
      end
      ENCODE: begin
        if (legal) begin
          wdata_d = word;
          state_d = WRITE;
        end else begin
          err_d   = 1'b1;
          state_d = fld_q.last ? FINISH : FILL;
        end
      end
      WRITE: begin
        if (!bus.MEM_BUSYWAIT) begin
          addr_d  = addr_q + ADDR_WIDTH'(4);
          count_d = count_q + COUNT_WIDTH'(1);
          state_d = fld_q.last ? FINISH : FILL;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      fld_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fld_q   <= fld_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.IN_READY      = (state_q == FILL);
  assign bus.MEM_WRITE     = (state_q == WRITE);
  assign bus.MEM_ADDR      = addr_q;
  assign bus.MEM_WRITEDATA = wdata_q;
  assign bus.COUNT         = count_q;
  assign bus.ERROR         = err_q;
  assign bus.DONE          = (state_q == FINISH);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder against
// an arithmetic reference model of RV32IM field packing.
module tb_instr_encoder;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  instr_encoder_if #(.ADDR_WIDTH(32), .COUNT_WIDTH(16)) bus ();

  instr_encoder #(.ADDR_WIDTH(32), .COUNT_WIDTH(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned fmt;
    int unsigned op;
    int unsigned f3;
    int unsigned f7;
    int unsigned rd;
    int unsigned rs1;
    int unsigned rs2;
    int          imm;
    bit          last;
  } bnd_t;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_addr;
  logic [15:0] exp_count;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Reference packing written from the field tables with
  // integer arithmetic; legality from signed ranges.
  function automatic void model(input bnd_t b,
                                output logic [31:0] w,
                                output bit ok);
    int unsigned u;
    bit sh;
    u  = b.imm;
    sh = (b.fmt == 1) && (b.op == 32'h13) &&
         (b.f3 == 1 || b.f3 == 5);
    ok = (b.op % 4 == 3) && (b.fmt <= 5);
    w  = 0;
    case (b.fmt)
      0: w = (b.f7 << 25) | (b.rs2 << 20) | (b.rs1 << 15) |
             (b.f3 << 12) | (b.rd << 7) | b.op;
      1: begin
        if (sh) begin
          ok = ok && b.imm >= 0 && b.imm < 32;
          w  = (b.f7 << 25) | ((u % 32) << 20) |
               (b.rs1 << 15) | (b.f3 << 12) |
               (b.rd << 7) | b.op;
        end else begin
          ok = ok && b.imm >= -2048 && b.imm <= 2047;
          w  = ((u % 4096) << 20) | (b.rs1 << 15) |
               (b.f3 << 12) | (b.rd << 7) | b.op;
        end
      end
      2: begin
        ok = ok && b.imm >= -2048 && b.imm <= 2047;
        w  = (((u / 32) % 128) << 25) | (b.rs2 << 20) |
             (b.rs1 << 15) | (b.f3 << 12) |
             ((u % 32) << 7) | b.op;
      end
      3: begin
        ok = ok && b.imm >= -4096 && b.imm <= 4094 &&
             (b.imm % 2 == 0);
        w  = (((u / 4096) % 2) << 31) |
             (((u / 32) % 64) << 25) |
             (b.rs2 << 20) | (b.rs1 << 15) | (b.f3 << 12) |
             (((u / 2) % 16) << 8) |
             (((u / 2048) % 2) << 7) | b.op;
      end
      4: begin
        ok = ok && (u % 4096 == 0);
        w  = (u - (u % 4096)) | (b.rd << 7) | b.op;
      end
      5: begin
        ok = ok && b.imm >= -1048576 && b.imm <= 1048574 &&
             (b.imm % 2 == 0);
        w  = (((u / 1048576) % 2) << 31) |
             (((u / 2) % 1024) << 21) |
             (((u / 2048) % 2) << 20) |
             (((u / 4096) % 256) << 12) |
             (b.rd << 7) | b.op;
      end
      default: w = 0;
    endcase
  endfunction

  function automatic bnd_t mk(int unsigned fmt, int unsigned op,
                              int unsigned f3, int unsigned f7,
                              int unsigned rd, int unsigned rs1,
                              int unsigned rs2, int imm, bit last);
    bnd_t b;
    b.fmt = fmt; b.op = op; b.f3 = f3; b.f7 = f7;
    b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
    b.imm = imm; b.last = last;
    return b;
  endfunction

  function automatic bnd_t rnd(bit last);
    bnd_t b;
    int unsigned r;
    b.fmt  = $urandom_range(0, 7);
    b.f3   = $urandom_range(0, 7);
    b.f7   = $urandom_range(0, 127);
    b.rd   = $urandom_range(0, 31);
    b.rs1  = $urandom_range(0, 31);
    b.rs2  = $urandom_range(0, 31);
    b.last = last;
    case (b.fmt)
      0: b.op = 32'h33;
      1: b.op = ($urandom_range(0, 1) == 1) ? 32'h03 : 32'h13;
      2: b.op = 32'h23;
      3: b.op = 32'h63;
      4: b.op = ($urandom_range(0, 1) == 1) ? 32'h17 : 32'h37;
      5: b.op = 32'h6F;
      default: b.op = 32'h33;
    endcase
    r = $urandom_range(0, 4);
    case (r)
      0: b.imm = int'($urandom_range(0, 8191)) - 4096;
      1: b.imm = int'($urandom_range(0, 2097151)) - 1048576;
      2: b.imm = int'($urandom);
      3: b.imm = int'($urandom & 32'hFFFF_F000);
      default: b.imm = int'($urandom_range(0, 4095)) - 2048;
    endcase
    if ($urandom_range(0, 1) == 1) b.imm = b.imm & ~1;
    if (b.fmt == 1 && $urandom_range(0, 2) == 0) begin
      b.op  = 32'h13;
      b.f3  = ($urandom_range(0, 1) == 1) ? 5 : 1;
      b.f7  = ($urandom_range(0, 1) == 1) ? 32 : 0;
      b.imm = int'($urandom_range(0, 40));
    end
    if ($urandom_range(0, 9) == 0) b.op = $urandom_range(0, 127);
    return b;
  endfunction

  task automatic start(input logic [31:0] base);
    bus.START = 1'b1;
    bus.BASE_ADDR = base;
    tick();
    bus.START = 1'b0;
    exp_addr = base;
    exp_count = 16'd0;
    chk("start_count", 64'(bus.COUNT), 64'(exp_count));
    chk("start_ready", 64'(bus.IN_READY), 64'(1));
  endtask

  task automatic drive(input bnd_t b);
    bus.FORMAT = b.fmt[2:0];
    bus.OPCODE = b.op[6:0];
    bus.FUNCT3 = b.f3[2:0];
    bus.FUNCT7 = b.f7[6:0];
    bus.RD     = b.rd[4:0];
    bus.RS1    = b.rs1[4:0];
    bus.RS2    = b.rs2[4:0];
    bus.IMM    = b.imm;
    bus.LAST   = b.last;
  endtask

  task automatic send(input bnd_t b, input bit ok,
                      input logic [31:0] w, input int busy);
    int t = 0;
    while (bus.IN_READY !== 1'b1 && t < 10) begin
      tick();
      t++;
    end
    chk("in_ready", 64'(bus.IN_READY), 64'(1));
    drive(b);
    bus.IN_VALID = 1'b1;
    tick();
    bus.IN_VALID = 1'b0;
    chk("enc_ready", 64'(bus.IN_READY), 64'(0));
    chk("enc_wr", 64'(bus.MEM_WRITE), 64'(0));
    tick();
    if (ok) begin
      for (int k = 0; k <= busy; k++) begin
        chk("wr", 64'(bus.MEM_WRITE), 64'(1));
        chk("addr", 64'(bus.MEM_ADDR), 64'(exp_addr));
        chk("data", 64'(bus.MEM_WRITEDATA), 64'(w));
        chk("wr_ready", 64'(bus.IN_READY), 64'(0));
        chk("wr_count", 64'(bus.COUNT), 64'(exp_count));
        bus.MEM_BUSYWAIT = (k < busy);
        tick();
      end
      bus.MEM_BUSYWAIT = 1'b0;
      exp_addr  = exp_addr + 32'd4;
      exp_count = exp_count + 16'd1;
      chk("wr_drop", 64'(bus.MEM_WRITE), 64'(0));
      chk("no_err", 64'(bus.ERROR), 64'(0));
    end else begin
      chk("err", 64'(bus.ERROR), 64'(1));
      chk("err_no_wr", 64'(bus.MEM_WRITE), 64'(0));
    end
    chk("count", 64'(bus.COUNT), 64'(exp_count));
    if (b.last) begin
      chk("done", 64'(bus.DONE), 64'(1));
      tick();
      chk("done_drop", 64'(bus.DONE), 64'(0));
      chk("idle_ready", 64'(bus.IN_READY), 64'(0));
      chk("count_hold", 64'(bus.COUNT), 64'(exp_count));
    end else begin
      chk("ready_back", 64'(bus.IN_READY), 64'(1));
      chk("no_done", 64'(bus.DONE), 64'(0));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr"}, 64'(bus.MEM_WRITE), 64'(0));
    chk({tag, "_addr"}, 64'(bus.MEM_ADDR), 64'(0));
    chk({tag, "_data"}, 64'(bus.MEM_WRITEDATA), 64'(0));
    chk({tag, "_count"}, 64'(bus.COUNT), 64'(0));
    chk({tag, "_ready"}, 64'(bus.IN_READY), 64'(0));
    chk({tag, "_err"}, 64'(bus.ERROR), 64'(0));
    chk({tag, "_done"}, 64'(bus.DONE), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bnd_t b;
    logic [31:0] w;
    bit ok;
    bus.START = 0; bus.BASE_ADDR = 0; bus.IN_VALID = 0;
    bus.MEM_BUSYWAIT = 0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    tick();
    chk_zero("reset");
    RESET = 1'b0;
    tick();
    chk_zero("idle");

    start(32'h100);
    send(mk(0, 32'h33, 0, 0, 3, 1, 2, 0, 0), 1, 32'h002081B3, 0);
    send(mk(0, 32'h33, 0, 32, 3, 1, 2, 0, 1), 1, 32'h402081B3, 0);
    chk("s1_count", 64'(bus.COUNT), 64'(2));

    start(32'h400);
    send(mk(0, 32'h33, 0, 1, 3, 1, 2, 0, 0), 1, 32'h022081B3, 0);
    send(mk(1, 32'h13, 0, 0, 5, 0, 0, -1, 0), 1, 32'hFFF00293, 0);
    send(mk(3, 32'h63, 0, 0, 0, 1, 2, -4, 0), 1, 32'hFE208EE3, 0);
    send(mk(3, 32'h63, 0, 0, 0, 1, 2, 3, 0), 0, 32'h0, 0);
    send(mk(0, 32'h33, 0, 0, 3, 1, 2, 0, 1), 1, 32'h002081B3, 3);
    chk("s2_count", 64'(bus.COUNT), 64'(4));

    start(32'h200);
    drive(mk(0, 32'h33, 0, 0, 3, 1, 2, 0, 1));
    bus.IN_VALID = 1'b1;
    tick();
    bus.IN_VALID = 1'b0;
    tick();
    bus.MEM_BUSYWAIT = 1'b1;
    tick();
    chk("pre_rst_wr", 64'(bus.MEM_WRITE), 64'(1));
    RESET = 1'b1;
    #1;
    chk_zero("mid_rst");
    tick();
    RESET = 1'b0;
    bus.MEM_BUSYWAIT = 1'b0;
    tick();
    chk_zero("post_rst");
    start(32'h300);
    send(mk(0, 32'h33, 0, 0, 3, 1, 2, 0, 1), 1, 32'h002081B3, 0);
    chk("rst_addr", 64'(exp_addr), 64'(32'h304));

    start(32'hFFFF_FFFC);
    bus.START = 1'b1;
    bus.BASE_ADDR = 32'h500;
    tick();
    bus.START = 1'b0;
    chk("start_ign", 64'(bus.IN_READY), 64'(1));
    send(mk(0, 32'h33, 0, 0, 3, 1, 2, 0, 0), 1, 32'h002081B3, 0);
    chk("wrap_addr", 64'(exp_addr), 64'(0));
    send(mk(0, 32'h33, 0, 32, 3, 1, 2, 0, 1), 1, 32'h402081B3, 0);

    for (int s = 0; s < 4; s++) begin
      start($urandom & 32'hFFFF_FFFC);
      for (int i = 0; i < 15; i++) begin
        b = rnd(i == 14);
        model(b, w, ok);
        send(b, ok, w, int'($urandom_range(0, 2)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encodes RV32IM instructions; the inverse of controlUnit's decode path.
- Accepts one field bundle per handshake (format, opcode, funct3/funct7, register indices, immediate) and packs it into a 32-bit RV32IM word.
- Writes each word into instruction memory at consecutive word addresses.
- Used to load test programs into the pipelined CPU's instruction memory and to check the decoder against the same field encodings.

Parameters:
- ADDR_WIDTH, 32, instruction-memory byte-address width
- COUNT_WIDTH, 16, width of the words-written counter

Ports:
- CLK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  begin a load session; sampled only in IDLE
- BASE_ADDR  in  ADDR_WIDTH  first write address, captured on START
- IN_VALID  in  1  field bundle valid
- IN_READY  out  1  encoder can accept a bundle
- FORMAT  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal
- OPCODE  in  7  bits [6:0] of the word
- FUNCT3  in  3  bits [14:12] (R/I/S/B)
- FUNCT7  in  7  bits [31:25] (R, and I-type shifts)
- RD, RS1, RS2  in  5 each  register indices
- IMM  in  32  signed immediate, byte offset for B/J
- LAST  in  1  this bundle ends the session
- MEM_WRITE  out  1  instruction-memory write strobe
- MEM_ADDR  out  ADDR_WIDTH  write address
- MEM_WRITEDATA  out  32  encoded instruction
- MEM_BUSYWAIT  in  1  memory stall
- COUNT  out  COUNT_WIDTH  words written this session
- ERROR  out  1  one-cycle pulse: bundle rejected
- DONE  out  1  one-cycle pulse: session complete

Behaviour:
- Reset (asynchronous, active-high, honoured at any time including mid-write):
  - State goes to IDLE.
  - All outputs go to 0; the address register and COUNT clear.
  - A write in flight is abandoned.
- FSM states: IDLE, FILL, ENCODE, WRITE, FINISH.
- IDLE:
  - IN_READY=0.
  - On START=1: capture BASE_ADDR, clear COUNT, go to FILL.
- FILL:
  - IN_READY=1.
  - On IN_VALID&IN_READY: register all fields and LAST, go to ENCODE.
  - START is ignored in every state except IDLE.
- ENCODE (one cycle):
  - Build the word and run the legality checks.
  - If legal: latch the word into MEM_WRITEDATA, go to WRITE.
  - If illegal: pulse ERROR for the next cycle, skip the write, leave COUNT unchanged, go to FINISH if LAST else FILL.
- WRITE:
  - MEM_WRITE=1; MEM_ADDR and MEM_WRITEDATA are held stable.
  - The write completes on the rising edge where MEM_BUSYWAIT=0. On that edge: address += 4 (wraps modulo 2^ADDR_WIDTH), COUNT += 1 (wraps), go to FINISH if LAST else FILL.
  - MEM_WRITE drops in the cycle after completion.
- FINISH: DONE=1 for one cycle, then go to IDLE. COUNT holds its value until the next START.
- Minimum throughput: one word per 3 cycles.
- Packing (bits not listed are the named fields at their RV32 positions):
  - R: FUNCT7|RS2|RS1|FUNCT3|RD|OPCODE.
  - I: IMM[11:0] at [31:20].
  - I-type shift (OPCODE=0010011, FUNCT3=001/101): [31:25]=FUNCT7, [24:20]=IMM[4:0].
  - S: IMM[11:5] at [31:25], IMM[4:0] at [11:7].
  - B: IMM[12] at 31, IMM[10:5] at [30:25], IMM[4:1] at [11:8], IMM[11] at 7.
  - U: IMM[31:12] at [31:12].
  - J: IMM[20] at 31, IMM[10:1] at [30:21], IMM[11] at 20, IMM[19:12] at [19:12].
- Illegal bundle (triggers ERROR):
  - FORMAT is 6 or 7.
  - I/S: IMM outside -2048..2047.
  - I-type shift: IMM[31:5] != 0.
  - B: IMM outside -4096..4094, or IMM odd.
  - J: IMM outside -1048576..1048574, or IMM odd.
  - U: IMM[11:0] != 0.
  - OPCODE[1:0] != 11.

Test Plan:
- START with BASE_ADDR=0x100; send add x3,x1,x2 (R, OPCODE=0110011, F7=0) then sub (F7=0100000, LAST=1) -> writes 0x002081B3@0x100 and 0x402081B3@0x104, COUNT=2, DONE pulses once.
- mul x3,x1,x2 (R, F7=0000001) then addi x5,x0,-1 (I, OPCODE=0010011, IMM=-1) -> 0x022081B3, 0xFFF00293.
- beq x1,x2,-4 (B, OPCODE=1100011, IMM=-4) -> 0xFE208EE3; repeat with IMM=3 -> ERROR pulse, no MEM_WRITE, COUNT unchanged, IN_READY returns 2 cycles later.
- Hold MEM_BUSYWAIT=1 for 3 cycles during a write -> MEM_WRITE/ADDR/DATA stable for 4 cycles, IN_READY=0 throughout, exactly one COUNT increment.
- Assert RESET while in WRITE with busywait high -> all outputs 0 immediately; a new START restarts cleanly at the new BASE_ADDR.
- START pulsed during FILL, and BASE_ADDR=0xFFFFFFFC with two words -> START ignored; second write goes to address 0x0 (wrap).
